acc_resp_adapter: RTL and testbench
===================================

ACC_RESP_ADAPTER -- requirements
Module: acc_resp_adapter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- Depth, 4, request FIFO entries, power of two, >=2.
- TransIdBits, 3, trans_id width.
REQ-002 Ports (name direction width meaning), one per line:
- clk_i  in  1  clock; reset is synchronous and active-low.
- rst_ni  in  1  synchronous active-low reset.
- req_valid_i  in  1  dispatcher request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- insn_i  in  32  instruction word.
- rs1_i, rs2_i  in  64  operands.
- frm_i  in  3  rounding mode (stored, unused by datapath).
- trans_id_i  in  TransIdBits  transaction id.
- store_pending_i  in  1  core has scalar stores in flight.
- acc_cons_en_i  in  1  memory-consistent mode.
- inval_ready_i  in  1  cache accepted invalidation.
- resp_ready_i  in  1  dispatcher accepts response.
- resp_valid_o  out  1  response valid.
- resp_trans_id_o  out  TransIdBits  response id.
- resp_result_o  out  64  result.
- exc_valid_o  out  1  exception flag.
- exc_cause_o  out  64  exception cause.
- exc_tval_o  out  64  exception tval.
- fflags_valid_o  out  1  constant 0.
- fflags_o  out  5  constant 0.
- store_pending_o  out  1  accelerator store queued or in flight.
- load_complete_o  out  1  one-cycle pulse per finished load.
- store_complete_o  out  1  one-cycle pulse per finished store.
- inval_valid_o  out  1  invalidation request.
- inval_addr_o  out  64  invalidation address.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_we_o  out  1  1=write.
- mem_addr_o  out  64  address (rs1).
- mem_wdata_o  out  64  write data (rs2).
- mem_rsp_valid_i  in  1  load data returned.
- mem_rdata_i  in  64  load data.

Function
REQ-003 Decode insn_i[6:0]: 7'h07 LOAD, 7'h27 STORE, 7'h57 ARITH, anything else ILLEGAL.
REQ-004 Request FIFO: Depth entries, not fall-through; req_ready_o = !full; push on req_valid_i && req_ready_o; entry visible at head the cycle after push; full with simultaneous pop still deasserts req_ready_o.
REQ-005 FSM states IDLE, MEM_REQ, MEM_WAIT, INVAL, RESP; one instruction in service at a time; responses strictly in acceptance order.
REQ-006 IDLE: FIFO non-empty -> pop head into service register; ARITH/ILLEGAL -> RESP; LOAD/STORE -> MEM_REQ.
REQ-007 ARITH result = rs1 + rs2, modulo 2^64; exc_valid_o=0.
REQ-008 ILLEGAL: exc_valid_o=1, exc_cause_o=2, exc_tval_o=zero-extended insn, result=0.
REQ-009 MEM_REQ: mem_req_valid_o=1, held with stable addr/we/wdata until mem_req_ready_i; for LOAD, valid withheld while acc_cons_en_i && store_pending_i. On handshake: LOAD -> MEM_WAIT, STORE -> INVAL.
REQ-010 MEM_WAIT: on mem_rsp_valid_i capture mem_rdata_i as result, pulse load_complete_o that cycle, -> RESP.
REQ-011 INVAL: inval_valid_o=1, inval_addr_o=rs1 until inval_ready_i; on handshake pulse store_complete_o, result=0, -> RESP.
REQ-012 RESP: resp_valid_o=1 with stable id/result/exception until resp_ready_i; on handshake -> IDLE, and FIFO head may be popped next cycle (no same-cycle pop).
REQ-013 Latency: ARITH accepted cycle 0 -> popped cycle 1 -> resp_valid_o cycle 2 (resp_ready_i high).
REQ-014 store_pending_o = any STORE entry in FIFO || STORE in service in MEM_REQ/INVAL; combinational from state.
REQ-015 Outputs not listed as active in a state are 0; inval_addr_o/mem_* data 0 when not valid.
REQ-016 Simultaneous push and pop: both honored, occupancy unchanged.

Reset
REQ-017 rst_ni low at a clock edge: FIFO emptied, FSM=IDLE, all outputs 0 except req_ready_o=1 from next cycle; in-flight instruction discarded with no complete pulse.

Verification
REQ-018 ARITH rs1=5, rs2=7, id=3, resp_ready_i=1 -> resp_valid_o cycle 2, result=12, id=3, exc_valid_o=0.
REQ-019 ARITH rs1=2^64-1, rs2=1 -> result=0 (wrap).
REQ-020 LOAD rs1=0x1000 with acc_cons_en_i=1, store_pending_i=1 for 5 cycles -> mem_req_valid_o stays 0 until deasserted; rdata 0xAB -> load_complete_o pulse, result 0xAB.
REQ-021 STORE rs1=0x2000: store_pending_o=1 from accept until inval handshake; inval_addr_o=0x2000; store_complete_o single pulse; response result 0.
REQ-022 Depth+1 back-to-back requests, resp_ready_i=0 -> req_ready_o drops at full; releasing returns all ids in order.
REQ-023 insn 0x00000033 -> exc_valid_o=1, exc_cause_o=2, exc_tval_o=0x33; reset asserted mid-MEM_WAIT -> no pulse, req_ready_o=1 after reset.

Source files
------------

// File: rtl/acc_resp_adapter.sv
// Accelerator response adapter: queues dispatcher requests, runs them one at a time
// through memory/invalidation handshakes, and returns responses in acceptance order.
module acc_resp_adapter #(
    parameter int unsigned Depth       = 4,
    parameter int unsigned TransIdBits = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            insn_i,
    input  logic [63:0]            rs1_i,
    input  logic [63:0]            rs2_i,
    input  logic [2:0]             frm_i,
    input  logic [TransIdBits-1:0] trans_id_i,
    input  logic                   store_pending_i,
    input  logic                   acc_cons_en_i,
    input  logic                   inval_ready_i,
    input  logic                   resp_ready_i,
    output logic                   resp_valid_o,
    output logic [TransIdBits-1:0] resp_trans_id_o,
    output logic [63:0]            resp_result_o,
    output logic                   exc_valid_o,
    output logic [63:0]            exc_cause_o,
    output logic [63:0]            exc_tval_o,
    output logic                   fflags_valid_o,
    output logic [4:0]             fflags_o,
    output logic                   store_pending_o,
    output logic                   load_complete_o,
    output logic                   store_complete_o,
    output logic                   inval_valid_o,
    output logic [63:0]            inval_addr_o,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic                   mem_we_o,
    output logic [63:0]            mem_addr_o,
    output logic [63:0]            mem_wdata_o,
    input  logic                   mem_rsp_valid_i,
    input  logic [63:0]            mem_rdata_i
);
    localparam int unsigned AW = $clog2(Depth);

    typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, INVAL, RESP} state_e;
    typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_ARITH, OP_ILLEGAL} op_e;

    function automatic op_e decode_op(input logic [31:0] insn);
        case (insn[6:0])
            7'h07:   decode_op = OP_LOAD;
            7'h27:   decode_op = OP_STORE;
            7'h57:   decode_op = OP_ARITH;
            default: decode_op = OP_ILLEGAL;
        endcase
    endfunction

    function automatic logic signed [63:0] wrap_add(input logic signed [63:0] a,
                                                    input logic signed [63:0] b);
        wrap_add = a + b;
    endfunction

    logic [31:0]            fifo_insn [Depth];
    logic [63:0]            fifo_rs1  [Depth];
    logic [63:0]            fifo_rs2  [Depth];
    logic [2:0]             fifo_frm  [Depth];
    logic [TransIdBits-1:0] fifo_id   [Depth];

    logic [AW:0] wr_ptr, rd_ptr, store_cnt;
    logic        full, empty, push, pop, push_store, pop_store;
    op_e         head_op;
    logic [AW-1:0] rd_idx;

    state_e                 state;
    op_e                    svc_op;
    logic [31:0]            svc_insn;
    logic [63:0]            svc_rs1, svc_rs2, svc_result;
    logic [2:0]             svc_frm;
    logic [TransIdBits-1:0] svc_id;
    logic                   svc_exc;
    logic                   frm_unused;

    assign rd_idx     = rd_ptr[AW-1:0];
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign req_ready_o = !full;
    assign push       = req_valid_i && !full;
    assign pop        = (state == IDLE) && !empty;
    assign head_op    = decode_op(fifo_insn[rd_idx]);
    assign push_store = push && (decode_op(insn_i) == OP_STORE);
    assign pop_store  = pop && (head_op == OP_STORE);

    // Rounding mode is carried with the instruction for future FP operations.
    assign frm_unused = ^svc_frm;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_insn[wr_ptr[AW-1:0]] <= insn_i;
            fifo_rs1[wr_ptr[AW-1:0]]  <= rs1_i;
            fifo_rs2[wr_ptr[AW-1:0]]  <= rs2_i;
            fifo_frm[wr_ptr[AW-1:0]]  <= frm_i;
            fifo_id[wr_ptr[AW-1:0]]   <= trans_id_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            store_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            case ({push_store, pop_store})
                2'b10:   store_cnt <= store_cnt + (AW+1)'(1);
                2'b01:   store_cnt <= store_cnt - (AW+1)'(1);
                default: store_cnt <= store_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (pop) state <= (head_op == OP_LOAD || head_op == OP_STORE)
                                            ? MEM_REQ : RESP;
                MEM_REQ:  if (mem_req_valid_o && mem_req_ready_i)
                              state <= (svc_op == OP_LOAD) ? MEM_WAIT : INVAL;
                MEM_WAIT: if (mem_rsp_valid_i) state <= RESP;
                INVAL:    if (inval_ready_i) state <= RESP;
                RESP:     if (resp_ready_i) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // Service register: the single instruction currently being worked on.
    always_ff @(posedge clk_i) begin
        if (pop) begin
            svc_op     <= head_op;
            svc_insn   <= fifo_insn[rd_idx];
            svc_rs1    <= fifo_rs1[rd_idx];
            svc_rs2    <= fifo_rs2[rd_idx];
            svc_frm    <= fifo_frm[rd_idx];
            svc_id     <= fifo_id[rd_idx];
            svc_exc    <= (head_op == OP_ILLEGAL);
            svc_result <= (head_op == OP_ARITH) ? wrap_add(fifo_rs1[rd_idx], fifo_rs2[rd_idx])
                                                : 64'd0;
        end else if (state == MEM_WAIT && mem_rsp_valid_i) begin
            svc_result <= mem_rdata_i;
        end
    end

    assign mem_req_valid_o  = (state == MEM_REQ) &&
                              !(svc_op == OP_LOAD && acc_cons_en_i && store_pending_i);
    assign mem_we_o         = mem_req_valid_o && (svc_op == OP_STORE);
    assign mem_addr_o       = mem_req_valid_o ? svc_rs1 : 64'd0;
    assign mem_wdata_o      = mem_we_o ? svc_rs2 : 64'd0;

    assign inval_valid_o    = (state == INVAL);
    assign inval_addr_o     = inval_valid_o ? svc_rs1 : 64'd0;
    assign load_complete_o  = (state == MEM_WAIT) && mem_rsp_valid_i;
    assign store_complete_o = (state == INVAL) && inval_ready_i;
    assign store_pending_o  = (store_cnt != '0) ||
                              (svc_op == OP_STORE && (state == MEM_REQ || state == INVAL));

    assign resp_valid_o     = (state == RESP);
    assign resp_trans_id_o  = resp_valid_o ? svc_id : '0;
    assign resp_result_o    = resp_valid_o ? svc_result : 64'd0;
    assign exc_valid_o      = resp_valid_o && svc_exc;
    assign exc_cause_o      = exc_valid_o ? 64'd2 : 64'd0;
    assign exc_tval_o       = exc_valid_o ? {32'd0, svc_insn} : 64'd0;

    assign fflags_valid_o   = 1'b0;
    assign fflags_o         = 5'd0;

endmodule

// File: tb/tb_acc_resp_adapter.sv
// Scoreboard bench for acc_resp_adapter: directed requests push expected responses,
// a monitor pops and compares on every response handshake.
module tb_acc_resp_adapter;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o;
    logic [31:0] insn_i;
    logic [63:0] rs1_i, rs2_i;
    logic [2:0]  frm_i, trans_id_i;
    logic        store_pending_i, acc_cons_en_i, inval_ready_i, resp_ready_i;
    logic        resp_valid_o;
    logic [2:0]  resp_trans_id_o;
    logic [63:0] resp_result_o, exc_cause_o, exc_tval_o;
    logic        exc_valid_o, fflags_valid_o;
    logic [4:0]  fflags_o;
    logic        store_pending_o, load_complete_o, store_complete_o;
    logic        inval_valid_o;
    logic [63:0] inval_addr_o;
    logic        mem_req_valid_o, mem_req_ready_i, mem_we_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic        mem_rsp_valid_i;
    logic [63:0] mem_rdata_i;

    acc_resp_adapter #(.Depth(4), .TransIdBits(3)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .insn_i(insn_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .frm_i(frm_i),
        .trans_id_i(trans_id_i), .store_pending_i(store_pending_i),
        .acc_cons_en_i(acc_cons_en_i), .inval_ready_i(inval_ready_i),
        .resp_ready_i(resp_ready_i), .resp_valid_o(resp_valid_o),
        .resp_trans_id_o(resp_trans_id_o), .resp_result_o(resp_result_o),
        .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o),
        .fflags_valid_o(fflags_valid_o), .fflags_o(fflags_o),
        .store_pending_o(store_pending_o), .load_complete_o(load_complete_o),
        .store_complete_o(store_complete_o), .inval_valid_o(inval_valid_o),
        .inval_addr_o(inval_addr_o), .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  id;
        logic [63:0] res;
        logic        exc;
        logic [63:0] cause;
        logic [63:0] tval;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          passes = 0;
    int          load_pulses = 0;
    int          store_pulses = 0;
    logic        rsp_en = 1'b1;
    logic [63:0] rdata_val = 64'h0;

    localparam logic [31:0] I_LOAD  = 32'h0000_0007;
    localparam logic [31:0] I_STORE = 32'h0000_0027;
    localparam logic [31:0] I_ARITH = 32'h0000_0057;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Response monitor and pulse counters
    initial forever begin
        @(negedge clk);
        if (load_complete_o)  load_pulses++;
        if (store_complete_o) store_pulses++;
        if (resp_valid_o && resp_ready_i) begin
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got id %0d, required no response", resp_trans_id_o);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("resp_id",     64'(resp_trans_id_o), 64'(e.id));
                chk("resp_result", resp_result_o, e.res);
                chk("exc_valid",   64'(exc_valid_o), 64'(e.exc));
                chk("exc_cause",   exc_cause_o, e.cause);
                chk("exc_tval",    exc_tval_o, e.tval);
            end
        end
    end

    // Memory model: answers each load handshake one cycle later
    initial forever begin
        @(negedge clk);
        if (mem_req_valid_o && mem_req_ready_i && !mem_we_o) begin
            @(posedge clk); #1;
            if (rsp_en) begin
                mem_rsp_valid_i = 1'b1;
                mem_rdata_i     = rdata_val;
                @(posedge clk); #1;
                mem_rsp_valid_i = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] insn, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] id, input bit expect_resp, input logic [63:0] res,
                        input logic exc, input logic [63:0] cause, input logic [63:0] tval);
        logic rdy;
        int   n;
        exp_t e;
        req_valid_i = 1'b1; insn_i = insn; rs1_i = a; rs2_i = b; trans_id_i = id;
        frm_i = 3'd1;
        n = 0;
        do begin
            @(negedge clk); rdy = req_ready_o;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        req_valid_i = 1'b0;
        if (!rdy) chk("send_accept_timeout", 64'(n), 64'd0);
        else if (expect_resp) begin
            e.id = id; e.res = res; e.exc = exc; e.cause = cause; e.tval = tval;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk); n++;
        end
        chk("drain_timeout", 64'(sbq.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int   lp0, sp0;
        logic seen;
        rst_ni = 1'b0; req_valid_i = 1'b0; insn_i = '0; rs1_i = '0; rs2_i = '0;
        frm_i = '0; trans_id_i = '0; store_pending_i = 1'b0; acc_cons_en_i = 1'b0;
        inval_ready_i = 1'b1; resp_ready_i = 1'b1; mem_req_ready_i = 1'b1;
        mem_rsp_valid_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready",   64'(req_ready_o), 64'd1);
        chk("rst_resp_valid",  64'(resp_valid_o), 64'd0);
        chk("rst_mem_valid",   64'(mem_req_valid_o), 64'd0);
        chk("rst_store_pend",  64'(store_pending_o), 64'd0);
        chk("rst_inval_valid", 64'(inval_valid_o), 64'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // ARITH latency: accepted cycle 0, response valid cycle 2
        send(I_ARITH, 64'd5, 64'd7, 3'd3, 1'b1, 64'd12, 1'b0, 64'd0, 64'd0);
        chk("arith_lat_c1", 64'(resp_valid_o), 64'd0);
        @(posedge clk); #1;
        chk("arith_lat_c2", 64'(resp_valid_o), 64'd1);
        drain();

        send(I_ARITH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd4, 1'b1, 64'd0, 1'b0, 64'd0, 64'd0);
        drain();

        // Load held back while consistent mode sees scalar stores in flight
        acc_cons_en_i = 1'b1; store_pending_i = 1'b1; rdata_val = 64'hAB;
        lp0 = load_pulses;
        send(I_LOAD, 64'h1000, 64'd0, 3'd5, 1'b1, 64'hAB, 1'b0, 64'd0, 64'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (mem_req_valid_o) seen = 1'b1;
        end
        chk("load_withheld", 64'(seen), 64'd0);
        @(posedge clk); #1;
        store_pending_i = 1'b0;
        @(negedge clk);
        chk("load_req_valid", 64'(mem_req_valid_o), 64'd1);
        chk("load_req_addr",  mem_addr_o, 64'h1000);
        chk("load_req_we",    64'(mem_we_o), 64'd0);
        @(posedge clk); #1;
        drain();
        chk("load_pulses", 64'(load_pulses - lp0), 64'd1);
        acc_cons_en_i = 1'b0;

        // Store path with invalidation handshake
        inval_ready_i = 1'b0;
        sp0 = store_pulses;
        send(I_STORE, 64'h2000, 64'h55, 3'd2, 1'b1, 64'd0, 1'b0, 64'd0, 64'd0);
        chk("store_pend_queued", 64'(store_pending_o), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("store_req_we",    64'(mem_we_o), 64'd1);
        chk("store_req_wdata", mem_wdata_o, 64'h55);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("inval_valid",      64'(inval_valid_o), 64'd1);
        chk("inval_addr",       inval_addr_o, 64'h2000);
        chk("store_pend_inval", 64'(store_pending_o), 64'd1);
        inval_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("store_pend_done", 64'(store_pending_o), 64'd0);
        drain();
        chk("store_pulses", 64'(store_pulses - sp0), 64'd1);

        // Fill to capacity with responses blocked, then release in order
        resp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++)
            send(I_ARITH, 64'(i), 64'd16, 3'(i + 1), 1'b1, 64'(i + 16), 1'b0, 64'd0, 64'd0);
        chk("full_req_ready", 64'(req_ready_o), 64'd0);
        resp_ready_i = 1'b1;
        drain();
        chk("drained_req_ready", 64'(req_ready_o), 64'd1);

        send(32'h0000_0033, 64'd9, 64'd9, 3'd6, 1'b1, 64'd0, 1'b1, 64'd2, 64'h33);
        drain();

        // Reset while a load waits for its data
        rsp_en = 1'b0;
        lp0 = load_pulses;
        send(I_LOAD, 64'h3000, 64'd0, 3'd1, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        chk("midrst_req_ready",  64'(req_ready_o), 64'd1);
        chk("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
        mem_rsp_valid_i = 1'b1; mem_rdata_i = 64'hDEAD;
        repeat (2) begin
            @(posedge clk); #1;
        end
        mem_rsp_valid_i = 1'b0;
        rsp_en = 1'b1;
        chk("midrst_no_pulse", 64'(load_pulses - lp0), 64'd0);

        send(I_ARITH, 64'h100, 64'h23, 3'd7, 1'b1, 64'h123, 1'b0, 64'd0, 64'd0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
